// File: rtl/cpu_run_ctrl.sv
// ============================================================================
// cpu_run_ctrl : sequences CPU reset release, runs the core, detects halt or
//                timeout and reports cycle/instruction counts and halt PC.
//                Optional PC-stream signature when TRACE_SIG_EN is defined.
// Revision     : 1.0  initial release
// ============================================================================
`default_nettype none

module cpu_run_ctrl #(
  parameter int                 ADDR_W      = 32,
  parameter int                 INSTR_W     = 32,
  parameter int                 CNT_W       = 32,
  parameter int                 RST_HOLD    = 2,
  parameter int                 MAX_CYCLES  = 1024,
  parameter logic [INSTR_W-1:0] HALT_INSTR  = INSTR_W'(32'hEAFFFFFE),
  parameter int                 STALL_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic [INSTR_W-1:0] instr_in,
  output logic               cpu_rst,
  output logic               running,
  output logic               done,
  output logic               timeout,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   instr_cnt,
  output logic [ADDR_W-1:0]  halt_pc,
  output logic [31:0]        trace_sig
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HOLD    = 3'd1,
    S_RUN     = 3'd2,
    S_DONE    = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;

  localparam int               HOLD_W     = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
  localparam int               STALL_W    = $clog2(STALL_LIMIT + 1);
  localparam logic [STALL_W-1:0] STALL_HIT = STALL_W'(STALL_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] TMO_AT     = CNT_W'(MAX_CYCLES - 1);
  localparam bit               TMO_EN     = (MAX_CYCLES != 0);

  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [ADDR_W-1:0]   prev_pc_q, prev_pc_d;
  logic                cpu_rst_q, cpu_rst_d;
  logic                running_q, running_d;
  logic                done_q, done_d;
  logic                timeout_q, timeout_d;
  logic [CNT_W-1:0]    cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0]    instr_cnt_q, instr_cnt_d;
  logic [ADDR_W-1:0]   halt_pc_q, halt_pc_d;

  logic                w_is_halt_instr;
  logic [STALL_W-1:0]  w_stall_next;
  logic                w_halt;
  logic                w_timeout;
  logic                w_start_ok;
  logic                w_run_step;

  // A stall count of zero marks "no PC seen yet in this run", so the first
  // RUN cycle always starts a fresh streak of one.
  always_comb begin
    w_is_halt_instr = (instr_in == HALT_INSTR);
    w_stall_next    = ((stall_cnt_q != '0) && (pc_in == prev_pc_q))
                      ? stall_cnt_q + STALL_W'(1) : STALL_W'(1);
    w_halt          = w_is_halt_instr || (w_stall_next == STALL_HIT);
    w_timeout       = TMO_EN && (cycle_cnt_q == TMO_AT);
    w_start_ok      = start && ((state_q == S_IDLE) || (state_q == S_DONE) ||
                                (state_q == S_TIMEOUT));
    w_run_step      = (state_q == S_RUN) && !abort;
  end

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    stall_cnt_d = stall_cnt_q;
    prev_pc_d   = prev_pc_q;
    done_d      = done_q;
    timeout_d   = timeout_q;
    cycle_cnt_d = cycle_cnt_q;
    instr_cnt_d = instr_cnt_q;
    halt_pc_d   = halt_pc_q;

    case (state_q)
      S_IDLE, S_DONE, S_TIMEOUT: begin
        if (start) begin
          state_d     = S_HOLD;
          hold_cnt_d  = '0;
          done_d      = 1'b0;
          timeout_d   = 1'b0;
          cycle_cnt_d = '0;
          instr_cnt_d = '0;
          halt_pc_d   = '0;
        end
      end
      S_HOLD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d     = S_RUN;
          stall_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          stall_cnt_d = w_stall_next;
          prev_pc_d   = pc_in;
          if (cycle_cnt_q != CNT_MAX) begin
            cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
          end
          if (!w_is_halt_instr && (instr_cnt_q != CNT_MAX)) begin
            instr_cnt_d = instr_cnt_q + CNT_W'(1);
          end
          if (w_halt) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            halt_pc_d = pc_in;
          end else if (w_timeout) begin
            state_d   = S_TIMEOUT;
            timeout_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    cpu_rst_d = (state_d == S_RUN);
    running_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      hold_cnt_q  <= '0;
      stall_cnt_q <= '0;
      prev_pc_q   <= '0;
      cpu_rst_q   <= 1'b0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
      halt_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      prev_pc_q   <= prev_pc_d;
      cpu_rst_q   <= cpu_rst_d;
      running_q   <= running_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
      halt_pc_q   <= halt_pc_d;
    end
  end

  assign cpu_rst   = cpu_rst_q;
  assign running   = running_q;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;
  assign halt_pc   = halt_pc_q;

`ifdef TRACE_SIG_EN
  logic [31:0] trace_q, trace_d;
  logic [31:0] w_pc32;

  if (ADDR_W >= 32) begin : g_pc_trunc
    assign w_pc32 = pc_in[31:0];
  end else begin : g_pc_pad
    assign w_pc32 = {{(32-ADDR_W){1'b0}}, pc_in};
  end

  always_comb begin
    trace_d = trace_q;
    if (w_start_ok) begin
      trace_d = '0;
    end else if (w_run_step) begin
      trace_d = {trace_q[30:0], trace_q[31]} ^ w_pc32;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trace_q <= '0;
    end else begin
      trace_q <= trace_d;
    end
  end

  assign trace_sig = trace_q;
`else
  assign trace_sig = 32'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
// ============================================================================
// tb_cpu_run_ctrl : two differently parameterised controllers driven by shared
//                   directed and random stimulus, compared to a run model.
// Revision        : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cpu_run_ctrl;

  localparam logic [31:0] HALT = 32'hEAFFFFFE;
  localparam logic [31:0] NOP  = 32'hE3A00001;
`ifdef TRACE_SIG_EN
  localparam bit TRACE_ON = 1'b1;
`else
  localparam bit TRACE_ON = 1'b0;
`endif

  localparam int P_IDLE = 0, P_HOLD = 1, P_RUN = 2, P_DONE = 3, P_TMO = 4;

  typedef struct {
    int          phase;
    int          hold_left;
    longint      cyc;
    longint      ins;
    logic [31:0] hpc;
    logic [31:0] trace;
    logic        done;
    logic        tmo;
    logic [31:0] last_pc;
    int          streak;
  } mdl_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] instr = NOP;

  logic        a_cpu_rst, a_running, a_done, a_timeout;
  logic [31:0] a_cycle_cnt, a_instr_cnt, a_halt_pc, a_trace;
  logic        b_cpu_rst, b_running, b_done, b_timeout;
  logic [3:0]  b_cycle_cnt, b_instr_cnt;
  logic [31:0] b_halt_pc, b_trace;

  int n_checks = 0;
  int n_errors = 0;
  mdl_t ma, mb;

  always #5 clk = ~clk;

  cpu_run_ctrl #(
    .ADDR_W(32), .INSTR_W(32), .CNT_W(32), .RST_HOLD(2),
    .MAX_CYCLES(6), .HALT_INSTR(HALT), .STALL_LIMIT(4)
  ) u_dut_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .pc_in(pc), .instr_in(instr),
    .cpu_rst(a_cpu_rst), .running(a_running), .done(a_done),
    .timeout(a_timeout), .cycle_cnt(a_cycle_cnt), .instr_cnt(a_instr_cnt),
    .halt_pc(a_halt_pc), .trace_sig(a_trace)
  );

  cpu_run_ctrl #(
    .ADDR_W(32), .INSTR_W(32), .CNT_W(4), .RST_HOLD(1),
    .MAX_CYCLES(0), .HALT_INSTR(HALT), .STALL_LIMIT(3)
  ) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .pc_in(pc), .instr_in(instr),
    .cpu_rst(b_cpu_rst), .running(b_running), .done(b_done),
    .timeout(b_timeout), .cycle_cnt(b_cycle_cnt), .instr_cnt(b_instr_cnt),
    .halt_pc(b_halt_pc), .trace_sig(b_trace)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.phase = P_IDLE; m.hold_left = 0; m.cyc = 0; m.ins = 0;
    m.hpc = '0; m.trace = '0; m.done = 1'b0; m.tmo = 1'b0;
    m.last_pc = '0; m.streak = 0;
    return m;
  endfunction

  // One clock of the run rules: r/st/ab/p/in are the values seen at the edge.
  function automatic mdl_t step(mdl_t m, logic r, logic st, logic ab,
                                logic [31:0] p, logic [31:0] in,
                                int hold, int maxc, int stl, longint cmax);
    mdl_t n = m;
    bit   halt;
    if (!r) return mdl_reset();
    if (m.phase == P_IDLE || m.phase == P_DONE || m.phase == P_TMO) begin
      if (st) begin
        n = mdl_reset();
        n.phase = P_HOLD;
        n.hold_left = hold;
      end
    end else if (ab) begin
      n.phase = P_IDLE;
    end else if (m.phase == P_HOLD) begin
      n.hold_left = m.hold_left - 1;
      if (n.hold_left == 0) begin
        n.phase  = P_RUN;
        n.streak = 0;
      end
    end else begin
      n.streak  = (m.streak > 0 && p == m.last_pc) ? m.streak + 1 : 1;
      n.last_pc = p;
      halt      = (in == HALT) || (n.streak >= stl);
      n.cyc     = (m.cyc < cmax) ? m.cyc + 1 : cmax;
      if (in != HALT) n.ins = (m.ins < cmax) ? m.ins + 1 : cmax;
      n.trace   = {m.trace[30:0], m.trace[31]} ^ p;
      if (halt) begin
        n.phase = P_DONE;
        n.done  = 1'b1;
        n.hpc   = p;
      end else if (maxc != 0 && m.cyc == maxc - 1) begin
        n.phase = P_TMO;
        n.tmo   = 1'b1;
      end
    end
    return n;
  endfunction

  task automatic check_all();
    chk("a.cpu_rst",   a_cpu_rst,   ma.phase == P_RUN);
    chk("a.running",   a_running,   ma.phase == P_RUN);
    chk("a.done",      a_done,      ma.done);
    chk("a.timeout",   a_timeout,   ma.tmo);
    chk("a.cycle_cnt", a_cycle_cnt, ma.cyc);
    chk("a.instr_cnt", a_instr_cnt, ma.ins);
    chk("a.halt_pc",   a_halt_pc,   ma.hpc);
    chk("a.trace_sig", a_trace,     TRACE_ON ? ma.trace : 32'h0);
    chk("b.cpu_rst",   b_cpu_rst,   mb.phase == P_RUN);
    chk("b.running",   b_running,   mb.phase == P_RUN);
    chk("b.done",      b_done,      mb.done);
    chk("b.timeout",   b_timeout,   mb.tmo);
    chk("b.cycle_cnt", b_cycle_cnt, mb.cyc);
    chk("b.instr_cnt", b_instr_cnt, mb.ins);
    chk("b.halt_pc",   b_halt_pc,   mb.hpc);
    chk("b.trace_sig", b_trace,     TRACE_ON ? mb.trace : 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    ma = step(ma, rst, start, abort, pc, instr, 2, 6, 4, 64'hFFFF_FFFF);
    mb = step(mb, rst, start, abort, pc, instr, 1, 0, 3, 64'd15);
    #1;
    check_all();
  endtask

  task automatic run_cycle(input logic [31:0] p, input logic [31:0] in);
    pc = p; instr = in;
    tick();
  endtask

  // Pulse start and walk through A's two hold cycles.
  task automatic launch();
    start = 1'b1; tick(); start = 1'b0;
    chk("hold1.cpu_rst", a_cpu_rst, 1'b0);
    tick();
    chk("hold2.cpu_rst", a_cpu_rst, 1'b0);
    tick();
    chk("run.cpu_rst", a_cpu_rst, 1'b1);
    chk("run.running", a_running, 1'b1);
  endtask

  task automatic async_reset();
    #2 rst = 1'b0;
    ma = mdl_reset();
    mb = mdl_reset();
    #1;
    check_all();
    chk("areset.cpu_rst", a_cpu_rst, 1'b0);
    start = 1'b0; abort = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    ma = mdl_reset();
    mb = mdl_reset();
    #1;
    check_all();
    tick(); tick();
    rst = 1'b1;
    tick();

    // B runs 20 cycles with no halt and no budget: counters pin at 15.
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 20; i++) run_cycle(32'h100 + 32'(i) * 4, NOP);
    chk("sat.b_cycle_cnt", b_cycle_cnt, 4'hF);
    chk("sat.b_instr_cnt", b_instr_cnt, 4'hF);
    chk("sat.a_timeout",   a_timeout,   1'b1);
    run_cycle(32'h200, HALT);

    // Halt by opcode.
    pc = 32'h0; instr = NOP;
    launch();
    run_cycle(32'h0, NOP);
    run_cycle(32'h4, NOP);
    run_cycle(32'h8, HALT);
    chk("op.done",      a_done,      1'b1);
    chk("op.halt_pc",   a_halt_pc,   32'h8);
    chk("op.instr_cnt", a_instr_cnt, 32'd2);
    chk("op.cycle_cnt", a_cycle_cnt, 32'd3);
    chk("op.cpu_rst",   a_cpu_rst,   1'b0);

    // Halt by stall.
    launch();
    run_cycle(32'h0, NOP);
    for (int i = 0; i < 3; i++) run_cycle(32'h10, NOP);
    chk("stall.not_yet", a_done, 1'b0);
    run_cycle(32'h10, NOP);
    chk("stall.done",    a_done,    1'b1);
    chk("stall.halt_pc", a_halt_pc, 32'h10);

    // Timeout, then the same with a halt on the last budgeted cycle.
    launch();
    for (int i = 0; i < 6; i++) run_cycle(32'h40 + 32'(i) * 4, NOP);
    chk("tmo.timeout", a_timeout, 1'b1);
    chk("tmo.done",    a_done,    1'b0);
    chk("tmo.cycles",  a_cycle_cnt, 32'd6);
    launch();
    for (int i = 0; i < 5; i++) run_cycle(32'h80 + 32'(i) * 4, NOP);
    run_cycle(32'h94, HALT);
    chk("tmo_halt.done",    a_done,    1'b1);
    chk("tmo_halt.timeout", a_timeout, 1'b0);

    // Abort at cycle_cnt=3, then async reset mid-run.
    launch();
    for (int i = 0; i < 3; i++) run_cycle(32'hC0 + 32'(i) * 4, NOP);
    abort = 1'b1; run_cycle(32'hCC, NOP); abort = 1'b0;
    chk("abort.cycle_cnt", a_cycle_cnt, 32'd3);
    chk("abort.cpu_rst",   a_cpu_rst,   1'b0);
    chk("abort.running",   a_running,   1'b0);
    launch();
    run_cycle(32'h0, NOP);
    async_reset();

    // Random traffic.
    pc = 32'h1000;
    for (int i = 0; i < 2500; i++) begin
      start = ($urandom_range(0, 7) == 0);
      abort = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 9) < 7) pc = pc + 32'd4;
      instr = ($urandom_range(0, 11) == 0) ? HALT : $urandom;
      if ($urandom_range(0, 299) == 0) async_reset();
      else tick();
    end
    start = 1'b0; abort = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
